// File: rtl/pcrel_unit.sv
// pcrel_unit
//   PC-relative execute block: AUIPC, JAL, JALR and conditional branches,
//   with compressed-instruction link addresses, target-alignment and
//   illegal-funct3 exceptions, followed by a DEPTH-entry result FIFO with
//   valid/ready handshakes on both sides.
//
// Parameters
//   XLEN   datapath / address width
//   DEPTH  result queue entries (power of two, >= 1)
//   C_EXT  1: 2-byte target alignment and 16-bit instructions allowed
//          0: 4-byte target alignment, 16-bit instructions are illegal
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   flush               synchronous kill of all queued results
//   in_valid/in_ready   issue handshake; in_ready = (count < DEPTH)
//   in_op               00 AUIPC, 01 JAL, 10 BRANCH, 11 JALR
//   in_funct3           branch condition
//   in_pc, in_imm       instruction address, sign-extended immediate
//   in_rs1_val/rs2_val  operands
//   in_rd, in_clen      destination index, instruction is 16-bit
//   out_valid/out_ready result handshake, head of queue
//   out_rd_idx/rd_val   writeback index and value
//   out_br_valid/target redirect request and address
//   out_ex_valid/cause  exception (0 misaligned target, 2 illegal)
module pcrel_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter bit C_EXT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [4:0]      in_rd,
    input  logic            in_clen,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd_idx,
    output logic [XLEN-1:0] out_rd_val,
    output logic            out_br_valid,
    output logic [XLEN-1:0] out_br_target,
    output logic            out_ex_valid,
    output logic [3:0]      out_ex_cause
);

    typedef enum logic [1:0] {
        OP_AUIPC  = 2'b00,
        OP_JAL    = 2'b01,
        OP_BRANCH = 2'b10,
        OP_JALR   = 2'b11
    } op_e;

    localparam int EW = 5 + XLEN + 1 + XLEN + 1 + 4;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // ------------------------------------------------------------------
    // Combinational result computation
    // ------------------------------------------------------------------
    op_e             op;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] pc_imm;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] res_val;
    logic            cond;
    logic            bad_f3;
    logic            taken;
    logic            illegal;
    logic            misaligned;
    logic            res_ex;
    logic            res_br;
    logic [3:0]      res_cause;
    logic            eq;
    logic            lt;
    logic            ltu;

    assign op = op_e'(in_op);

    always_comb begin
        link     = in_pc + (in_clen ? XLEN'(2) : XLEN'(4));
        pc_imm   = in_pc + in_imm;
        jalr_sum = in_rs1_val + in_imm;

        eq  = (in_rs1_val == in_rs2_val);
        lt  = ($signed(in_rs1_val) < $signed(in_rs2_val));
        ltu = (in_rs1_val < in_rs2_val);

        cond   = 1'b0;
        bad_f3 = 1'b0;
        case (in_funct3)
            3'b000:  cond = eq;
            3'b001:  cond = !eq;
            3'b100:  cond = lt;
            3'b101:  cond = !lt;
            3'b110:  cond = ltu;
            3'b111:  cond = !ltu;
            default: bad_f3 = 1'b1;
        endcase

        target = (op == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_imm;

        case (op)
            OP_JAL, OP_JALR: taken = 1'b1;
            OP_BRANCH:       taken = cond && !bad_f3;
            default:         taken = 1'b0;
        endcase

        illegal    = ((op == OP_BRANCH) && bad_f3) || (in_clen && !C_EXT);
        // Only a redirect that actually happens can fault on alignment.
        misaligned = taken && (C_EXT ? target[0] : (target[1:0] != 2'b00));
        res_ex     = illegal || misaligned;
        res_cause  = illegal ? 4'd2 : 4'd0;
        res_br     = taken && !res_ex;

        case (op)
            OP_AUIPC:        res_val = pc_imm;
            OP_JAL, OP_JALR: res_val = link;
            default:         res_val = '0;
        endcase
        if (res_ex) begin
            res_val = '0;
        end
    end

    // ------------------------------------------------------------------
    // Result queue
    // ------------------------------------------------------------------
    logic [EW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic [EW-1:0]   wr_entry;
    logic [EW-1:0]   head;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign wr_entry  = {in_rd, res_val, res_br, target, res_ex, res_cause};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    assign head = out_valid ? mem[rd_ptr] : '0;

    assign {out_rd_idx, out_rd_val, out_br_valid, out_br_target,
            out_ex_valid, out_ex_cause} = head;

endmodule

// File: tb/tb_pcrel_unit.sv
// Testbench for pcrel_unit: two instances (C_EXT=1 and C_EXT=0, DEPTH=2)
// share the issue bus; a scoreboard queue per instance holds expected
// results pushed on accept and checked as results are consumed.
module tb_pcrel_unit;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        clen;
        logic [31:0] e_val;
        logic        e_br;
        logic [31:0] e_tgt;
        logic        e_ex;
        logic [3:0]  e_cause;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        iv0 = 1'b0;
    logic        iv1 = 1'b0;
    logic        ir0, ir1;
    logic [1:0]  op = '0;
    logic [2:0]  f3 = '0;
    logic [31:0] pc = '0, imm = '0, rs1 = '0, rs2 = '0;
    logic [4:0]  rd = '0;
    logic        clen = 1'b0;

    logic        ov0, ov1, obr0, obr1, oex0, oex1;
    logic [4:0]  oidx0, oidx1;
    logic [31:0] oval0, oval1, otgt0, otgt1;
    logic [3:0]  ocause0, ocause1;

    int checks = 0;
    int errors = 0;
    vec_t sb0[$];
    vec_t sb1[$];
    vec_t tab0[13];
    vec_t tab1[6];

    always #5 clk = ~clk;

    pcrel_unit #(.XLEN(32), .DEPTH(2), .C_EXT(1'b1)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv0), .in_ready(ir0), .in_op(op), .in_funct3(f3),
        .in_pc(pc), .in_imm(imm), .in_rs1_val(rs1), .in_rs2_val(rs2),
        .in_rd(rd), .in_clen(clen),
        .out_valid(ov0), .out_ready(out_ready), .out_rd_idx(oidx0),
        .out_rd_val(oval0), .out_br_valid(obr0), .out_br_target(otgt0),
        .out_ex_valid(oex0), .out_ex_cause(ocause0)
    );

    pcrel_unit #(.XLEN(32), .DEPTH(2), .C_EXT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv1), .in_ready(ir1), .in_op(op), .in_funct3(f3),
        .in_pc(pc), .in_imm(imm), .in_rs1_val(rs1), .in_rs2_val(rs2),
        .in_rd(rd), .in_clen(clen),
        .out_valid(ov1), .out_ready(out_ready), .out_rd_idx(oidx1),
        .out_rd_val(oval1), .out_br_valid(obr1), .out_br_target(otgt1),
        .out_ex_valid(oex1), .out_ex_cause(ocause1)
    );

    function automatic vec_t mk(
        input logic [1:0] o, input logic [2:0] f, input logic [31:0] p,
        input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
        input logic [4:0] d, input logic c, input logic [31:0] ev,
        input logic eb, input logic [31:0] et, input logic ee,
        input logic [3:0] ec);
        vec_t v;
        v.op = o; v.f3 = f; v.pc = p; v.imm = i; v.rs1 = a; v.rs2 = b;
        v.rd = d; v.clen = c; v.e_val = ev; v.e_br = eb; v.e_tgt = et;
        v.e_ex = ee; v.e_cause = ec;
        return v;
    endfunction

    task automatic check1(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_out(input int which, input logic [4:0] a_idx,
                           input logic [31:0] a_val, input logic a_br,
                           input logic [31:0] a_tgt, input logic a_ex,
                           input logic [3:0] a_cause);
        vec_t e;
        checks++;
        if ((which == 0 && sb0.size() == 0) || (which == 1 && sb1.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_out dut%0d actual=valid expected=empty", which);
            return;
        end
        if (which == 0) e = sb0.pop_front();
        else            e = sb1.pop_front();
        if (a_idx !== e.rd || a_val !== e.e_val || a_br !== e.e_br ||
            a_tgt !== e.e_tgt || a_ex !== e.e_ex || a_cause !== e.e_cause) begin
            errors++;
            $display("FAIL result dut%0d actual rd=%0d val=%08h br=%0b tgt=%08h ex=%0b cause=%0d expected rd=%0d val=%08h br=%0b tgt=%08h ex=%0b cause=%0d",
                     which, a_idx, a_val, a_br, a_tgt, a_ex, a_cause,
                     e.rd, e.e_val, e.e_br, e.e_tgt, e.e_ex, e.e_cause);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (ov0 && out_ready) chk_out(0, oidx0, oval0, obr0, otgt0, oex0, ocause0);
            if (ov1 && out_ready) chk_out(1, oidx1, oval1, obr1, otgt1, oex1, ocause1);
        end
    end

    task automatic set_fields(input vec_t v);
        op = v.op; f3 = v.f3; pc = v.pc; imm = v.imm;
        rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; clen = v.clen;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int which, input vec_t v);
        int   tries;
        logic rdy;
        set_fields(v);
        if (which == 0) iv0 = 1'b1;
        else            iv1 = 1'b1;
        tries = 0;
        rdy = (which == 0) ? ir0 : ir1;
        while (!rdy && tries < 20) begin
            @(posedge clk); #1;
            tries++;
            rdy = (which == 0) ? ir0 : ir1;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout dut%0d in_ready actual=0 expected=1", which);
        end else begin
            if (which == 0) sb0.push_back(v);
            else            sb1.push_back(v);
            @(posedge clk); #1;
        end
        iv0 = 1'b0;
        iv1 = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check1("drain_left", sb0.size() + sb1.size(), 32'd0);
    endtask

    initial begin
        vec_t a1, a2, a3, a4, a5, f1, f2, f3v;

        tab0[0]  = mk(2'b01, 3'd0, 32'h1000, 32'h20, 32'h0, 32'h0, 5'd1, 1'b0, 32'h1004, 1'b1, 32'h1020, 1'b0, 4'd0);
        tab0[1]  = mk(2'b10, 3'b101, 32'h2000, 32'h10, 32'h5, 32'h5, 5'd0, 1'b0, 32'h0, 1'b1, 32'h2010, 1'b0, 4'd0);
        tab0[2]  = mk(2'b10, 3'b110, 32'h2000, 32'h10, 32'hFFFFFFFF, 32'h1, 5'd0, 1'b0, 32'h0, 1'b0, 32'h2010, 1'b0, 4'd0);
        tab0[3]  = mk(2'b10, 3'b100, 32'h2000, 32'h10, 32'hFFFFFFFF, 32'h1, 5'd0, 1'b0, 32'h0, 1'b1, 32'h2010, 1'b0, 4'd0);
        tab0[4]  = mk(2'b11, 3'd0, 32'h100, 32'h0, 32'h2001, 32'h0, 5'd5, 1'b1, 32'h102, 1'b1, 32'h2000, 1'b0, 4'd0);
        tab0[5]  = mk(2'b10, 3'b010, 32'h300, 32'h8, 32'h1, 32'h1, 5'd0, 1'b0, 32'h0, 1'b0, 32'h308, 1'b1, 4'd2);
        tab0[6]  = mk(2'b00, 3'd0, 32'h4000, 32'hFFFFF000, 32'h0, 32'h0, 5'd7, 1'b0, 32'h3000, 1'b0, 32'h3000, 1'b0, 4'd0);
        tab0[7]  = mk(2'b10, 3'b000, 32'h100, 32'h3, 32'h7, 32'h7, 5'd0, 1'b0, 32'h0, 1'b0, 32'h103, 1'b1, 4'd0);
        tab0[8]  = mk(2'b10, 3'b001, 32'h100, 32'h3, 32'h7, 32'h7, 5'd0, 1'b0, 32'h0, 1'b0, 32'h103, 1'b0, 4'd0);
        tab0[9]  = mk(2'b01, 3'd0, 32'hFFFFFFFE, 32'h4, 32'h0, 32'h0, 5'd9, 1'b1, 32'h0, 1'b1, 32'h2, 1'b0, 4'd0);
        tab0[10] = mk(2'b10, 3'b111, 32'h0, 32'h40, 32'h1, 32'hFFFFFFFF, 5'd0, 1'b0, 32'h0, 1'b0, 32'h40, 1'b0, 4'd0);
        tab0[11] = mk(2'b01, 3'd0, 32'h1000, 32'h21, 32'h0, 32'h0, 5'd11, 1'b0, 32'h0, 1'b0, 32'h1021, 1'b1, 4'd0);
        tab0[12] = mk(2'b10, 3'b011, 32'h800, 32'hFFFFFFF0, 32'h3, 32'h4, 5'd0, 1'b0, 32'h0, 1'b0, 32'h7F0, 1'b1, 4'd2);

        tab1[0] = mk(2'b11, 3'd0, 32'h100, 32'h0, 32'h2002, 32'h0, 5'd4, 1'b0, 32'h0, 1'b0, 32'h2002, 1'b1, 4'd0);
        tab1[1] = mk(2'b10, 3'b000, 32'h1000, 32'h1, 32'h1, 32'h2, 5'd0, 1'b0, 32'h0, 1'b0, 32'h1001, 1'b0, 4'd0);
        tab1[2] = mk(2'b01, 3'd0, 32'h200, 32'h10, 32'h0, 32'h0, 5'd6, 1'b1, 32'h0, 1'b0, 32'h210, 1'b1, 4'd2);
        tab1[3] = mk(2'b01, 3'd0, 32'h200, 32'h12, 32'h0, 32'h0, 5'd6, 1'b0, 32'h0, 1'b0, 32'h212, 1'b1, 4'd0);
        tab1[4] = mk(2'b01, 3'd0, 32'h200, 32'h14, 32'h0, 32'h0, 5'd6, 1'b0, 32'h204, 1'b1, 32'h214, 1'b0, 4'd0);
        tab1[5] = mk(2'b00, 3'd0, 32'h40, 32'h4, 32'h0, 32'h0, 5'd2, 1'b1, 32'h0, 1'b0, 32'h44, 1'b1, 4'd2);

        a1 = mk(2'b00, 3'd0, 32'h10, 32'h100, 32'h0, 32'h0, 5'd1, 1'b0, 32'h110, 1'b0, 32'h110, 1'b0, 4'd0);
        a2 = mk(2'b00, 3'd0, 32'h20, 32'h100, 32'h0, 32'h0, 5'd2, 1'b0, 32'h120, 1'b0, 32'h120, 1'b0, 4'd0);
        a3 = mk(2'b00, 3'd0, 32'h30, 32'h100, 32'h0, 32'h0, 5'd3, 1'b0, 32'h130, 1'b0, 32'h130, 1'b0, 4'd0);
        a4 = mk(2'b00, 3'd0, 32'h40, 32'h100, 32'h0, 32'h0, 5'd4, 1'b0, 32'h140, 1'b0, 32'h140, 1'b0, 4'd0);
        a5 = mk(2'b00, 3'd0, 32'h50, 32'h100, 32'h0, 32'h0, 5'd5, 1'b0, 32'h150, 1'b0, 32'h150, 1'b0, 4'd0);
        f1  = mk(2'b00, 3'd0, 32'h500, 32'h10, 32'h0, 32'h0, 5'd3, 1'b0, 32'h510, 1'b0, 32'h510, 1'b0, 4'd0);
        f2  = mk(2'b00, 3'd0, 32'h600, 32'h20, 32'h0, 32'h0, 5'd4, 1'b0, 32'h620, 1'b0, 32'h620, 1'b0, 4'd0);
        f3v = mk(2'b00, 3'd0, 32'h700, 32'h30, 32'h0, 32'h0, 5'd8, 1'b0, 32'h730, 1'b0, 32'h730, 1'b0, 4'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check1("rst_out_valid", {31'd0, ov0}, 32'd0);
        check1("rst_rd_val", oval0, 32'd0);
        check1("rst_br_target", otgt0, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check1("rst_in_ready0", {31'd0, ir0}, 32'd1);
        check1("rst_in_ready1", {31'd0, ir1}, 32'd1);
        check1("rst_out_valid1", {31'd0, ov1}, 32'd0);

        // Table-driven vectors, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) send(0, tab0[i]);
        for (int i = 0; i < 6; i++)  send(1, tab1[i]);
        drain();

        // Backpressure: fill, stall a third, then release
        out_ready = 1'b0;
        send(0, a1);
        check1("lat_out_valid", {31'd0, ov0}, 32'd1);
        send(0, a2);
        check1("full_out_valid", {31'd0, ov0}, 32'd1);
        check1("full_in_ready", {31'd0, ir0}, 32'd0);
        fork
            send(0, a3);
            begin
                @(posedge clk); #1;
                check1("stall_in_ready", {31'd0, ir0}, 32'd0);
                out_ready = 1'b1;
            end
        join
        check1("steady_in_ready_a", {31'd0, ir0}, 32'd1);
        send(0, a4);
        check1("steady_in_ready_b", {31'd0, ir0}, 32'd1);
        check1("steady_out_valid", {31'd0, ov0}, 32'd1);
        send(0, a5);
        drain();

        // Flush with a full queue and in_valid high
        out_ready = 1'b0;
        send(0, f1);
        send(0, f2);
        set_fields(f3v);
        iv0 = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        iv0 = 1'b0;
        check1("flush_full_out_valid", {31'd0, ov0}, 32'd0);
        check1("flush_full_in_ready", {31'd0, ir0}, 32'd1);
        check1("flush_full_rd_val", oval0, 32'd0);
        sb0.delete();

        // Flush discards an input accepted on the same edge
        send(0, f1);
        set_fields(f2);
        iv0 = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        iv0 = 1'b0;
        check1("flush_accept_out_valid", {31'd0, ov0}, 32'd0);
        sb0.delete();
        out_ready = 1'b1;
        send(0, f3v);
        drain();

        // Asynchronous reset between edges
        out_ready = 1'b0;
        send(0, f1);
        check1("pre_arst_out_valid", {31'd0, ov0}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check1("arst_out_valid", {31'd0, ov0}, 32'd0);
        check1("arst_rd_idx", {27'd0, oidx0}, 32'd0);
        check1("arst_rd_val", oval0, 32'd0);
        check1("arst_br_target", otgt0, 32'd0);
        check1("arst_flags", {29'd0, obr0, oex0, |ocause0}, 32'd0);
        rst = 1'b1;
        sb0.delete();
        @(posedge clk); #1;
        check1("post_arst_in_ready", {31'd0, ir0}, 32'd1);

        out_ready = 1'b1;
        send(0, tab0[0]);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
